// File: rtl/keylock_pkg.sv
// keylock_pkg: shared definitions for the keypad lock controller.
//   state_e            FSM state encoding; values are visible on state_o
//   DIGIT_W            bits per BCD digit
//   KEY_ENTER_DEF      default ENTER key code
//   KEY_CLR_DEF        default CLEAR key code
//   cnt_width()        width of a counter that holds 0..n
package keylock_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] KEY_ENTER_DEF = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_CLR_DEF   = 4'hB;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_OPEN     = 3'd1,
        ST_NEW_CODE = 3'd2,
        ST_CONFIRM  = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/keylock_entry_buf.sv
// keylock_entry_buf: digit entry shift register with saturating count.
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clr_i           clear buffer and count (wins over push_i)
//   push_i          shift digit_i in at the LSB nibble (ignored when full)
//   target_i        code compared against the buffer
//   buf_o, cnt_o    buffered digits and count
//   full_o          count == N_DIGITS
//   match_o         full and buffer == target_i
module keylock_entry_buf
    import keylock_pkg::*;
#(
    parameter int unsigned N_DIGITS = 6,
    parameter int unsigned CW       = DIGIT_W * N_DIGITS,
    parameter int unsigned NW       = cnt_width(N_DIGITS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic [CW-1:0]      target_i,
    output logic [CW-1:0]      buf_o,
    output logic [NW-1:0]      cnt_o,
    output logic               full_o,
    output logic               match_o
);

    logic [CW-1:0] shreg_q, shreg_d;
    logic [NW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == NW'(N_DIGITS));
    assign match_o = full_o && (shreg_q == target_i);
    assign buf_o   = shreg_q;
    assign cnt_o   = cnt_q;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (push_i && !full_o) begin
            shreg_d = (shreg_q << DIGIT_W) | CW'(digit_i);
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/keylock_core_p.sv
// keylock_core_p: keypad lock controller (user code, master reprogramming
// with confirmation, brute-force lockout).
//   hwclk, resetN       clock, synchronous active-low reset
//   key_valid, key      one-cycle key strobe and key code
//   lock_req            level, relocks from OPEN
//   unlocked            state == OPEN
//   ok_pulse/err_pulse  one-cycle result pulses
//   locked_out          state == LOCKOUT
//   state_o             current state encoding
//   digits_entered      digits currently buffered
// Optional: define KEYLOCK_TIMEOUT_EN for the inactivity timeout.
module keylock_core_p
    import keylock_pkg::*;
#(
    parameter int unsigned                N_DIGITS    = 6,
    parameter logic [4*N_DIGITS-1:0]      MASTER_CODE = 24'h555116,
    parameter logic [4*N_DIGITS-1:0]      RESET_UC    = 24'h666666,
    parameter int unsigned                MAX_TRIES   = 3,
    parameter int unsigned                LOCKOUT_CYC = 36000000,
    parameter int unsigned                TIMEOUT_CYC = 120000000,
    parameter logic [3:0]                 KEY_ENTER   = KEY_ENTER_DEF,
    parameter logic [3:0]                 KEY_CLR     = KEY_CLR_DEF
) (
    input  logic                          hwclk,
    input  logic                          resetN,
    input  logic                          key_valid,
    input  logic [3:0]                    key,
    input  logic                          lock_req,
    output logic                          unlocked,
    output logic                          ok_pulse,
    output logic                          err_pulse,
    output logic                          locked_out,
    output logic [2:0]                    state_o,
    output logic [cnt_width(N_DIGITS)-1:0] digits_entered
);

    localparam int unsigned CW = DIGIT_W * N_DIGITS;
    localparam int unsigned NW = cnt_width(N_DIGITS);
    localparam int unsigned FW = cnt_width(MAX_TRIES);
    localparam int unsigned TW = cnt_width(LOCKOUT_CYC);

    state_e        state_q, state_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] uc_q, uc_d;
    logic [CW-1:0] pend_q, pend_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;

    logic          enter, clr_key, is_digit;
    logic          clr_req, buf_clr, buf_push;
    logic [CW-1:0] buf_val, target;
    logic [NW-1:0] buf_cnt;
    logic          buf_full, buf_match, master_hit;

    assign enter    = key_valid && (key == KEY_ENTER);
    assign clr_key  = key_valid && (key == KEY_CLR);
    assign is_digit = key_valid && (key <= 4'd9);

    assign target     = (state_q == ST_CONFIRM) ? pend_q : uc_q;
    assign master_hit = buf_full && (buf_val == MASTER_CODE);

    keylock_entry_buf #(
        .N_DIGITS (N_DIGITS),
        .CW       (CW),
        .NW       (NW)
    ) u_buf (
        .clk_i    (hwclk),
        .rst_ni   (resetN),
        .clr_i    (buf_clr),
        .push_i   (buf_push),
        .digit_i  (key),
        .target_i (target),
        .buf_o    (buf_val),
        .cnt_o    (buf_cnt),
        .full_o   (buf_full),
        .match_o  (buf_match)
    );

`ifdef KEYLOCK_TIMEOUT_EN
    localparam int unsigned OW = cnt_width(TIMEOUT_CYC);
    logic [OW-1:0] to_q, to_d;

    always_ff @(posedge hwclk) begin
        if (!resetN) to_q <= '0;
        else         to_q <= to_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        uc_d    = uc_q;
        pend_d  = pend_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        clr_req = clr_key;

        case (state_q)
            ST_LOCKED: begin
                if (enter) begin
                    clr_req = 1'b1;
                    if (buf_match) begin
                        state_d = ST_OPEN;
                        ok_d    = 1'b1;
                        fail_d  = '0;
                    end else if (master_hit) begin
                        state_d = ST_NEW_CODE;
                        ok_d    = 1'b1;
                        fail_d  = '0;
                    end else begin
                        err_d  = 1'b1;
                        fail_d = fail_q + 1'b1;
                        if (fail_q == FW'(MAX_TRIES - 1)) begin
                            state_d = ST_LOCKOUT;
                            timer_d = TW'(LOCKOUT_CYC - 1);
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (lock_req) begin
                    state_d = ST_LOCKED;
                    ok_d    = 1'b1;
                end else if (enter) begin
                    clr_req = 1'b1;
                    if (buf_match) begin
                        state_d = ST_LOCKED;
                        ok_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_NEW_CODE: begin
                if (enter) begin
                    clr_req = 1'b1;
                    if (buf_full) begin
                        pend_d  = buf_val;
                        state_d = ST_CONFIRM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_CONFIRM: begin
                if (enter) begin
                    clr_req = 1'b1;
                    state_d = ST_LOCKED;
                    if (buf_match) begin
                        uc_d = pend_q;
                        ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_LOCKED;
        endcase

`ifdef KEYLOCK_TIMEOUT_EN
        // Idle counter only runs while something is pending; a key always
        // reloads it, so a timeout never coincides with an ENTER.
        to_d = '0;
        if (state_q != ST_LOCKOUT &&
            (buf_cnt != '0 || state_q == ST_NEW_CODE || state_q == ST_CONFIRM)) begin
            if (key_valid) begin
                to_d = '0;
            end else if (to_q == OW'(TIMEOUT_CYC - 1)) begin
                clr_req = 1'b1;
                if (state_q == ST_NEW_CODE || state_q == ST_CONFIRM) begin
                    state_d = ST_LOCKED;
                    err_d   = 1'b1;
                end
            end else begin
                to_d = to_q + 1'b1;
            end
        end
`endif

        // Any state change or lockout holds the buffer clear; a digit
        // arriving in such a cycle is dropped.
        buf_clr  = clr_req || (state_d != state_q) || (state_q == ST_LOCKOUT);
        buf_push = is_digit && !buf_clr;
    end

    always_ff @(posedge hwclk) begin
        if (!resetN) begin
            state_q <= ST_LOCKED;
            fail_q  <= '0;
            timer_q <= '0;
            uc_q    <= RESET_UC;
            pend_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            uc_q    <= uc_d;
            pend_q  <= pend_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign unlocked       = (state_q == ST_OPEN);
    assign locked_out     = (state_q == ST_LOCKOUT);
    assign state_o        = state_q;
    assign ok_pulse       = ok_q;
    assign err_pulse      = err_q;
    assign digits_entered = buf_cnt;

endmodule

// File: tb/tb_keylock_core_p.sv
module tb_keylock_core_p;

    logic       hwclk = 1'b0;
    logic       resetN;
    logic       key_valid;
    logic [3:0] key;
    logic       lock_req;
    logic       unlocked, ok_pulse, err_pulse, locked_out;
    logic [2:0] state_o;
    logic [2:0] digits_entered;

    int checks = 0;
    int errors = 0;

    keylock_core_p #(
        .N_DIGITS    (6),
        .MASTER_CODE (24'h555116),
        .RESET_UC    (24'h666666),
        .MAX_TRIES   (3),
        .LOCKOUT_CYC (50),
        .TIMEOUT_CYC (20)
    ) dut (
        .hwclk          (hwclk),
        .resetN         (resetN),
        .key_valid      (key_valid),
        .key            (key),
        .lock_req       (lock_req),
        .unlocked       (unlocked),
        .ok_pulse       (ok_pulse),
        .err_pulse      (err_pulse),
        .locked_out     (locked_out),
        .state_o        (state_o),
        .digits_entered (digits_entered)
    );

    always #5 hwclk = ~hwclk;

    // Drive on the falling edge; on return we sit at the falling edge right
    // after the rising edge that sampled the key, so results are visible.
    task automatic key_press(input logic [3:0] k);
        @(negedge hwclk);
        key_valid = 1'b1;
        key       = k;
        @(negedge hwclk);
        key_valid = 1'b0;
        key       = 4'h0;
    endtask

    task automatic enter_code(input logic [23:0] code);
        logic [23:0] c;
        c = code;
        for (int i = 0; i < 6; i++) key_press(c[23-4*i -: 4]);
        key_press(4'hA);
    endtask

    task automatic do_reset();
        @(negedge hwclk);
        resetN    = 1'b0;
        key_valid = 1'b0;
        key       = 4'h0;
        lock_req  = 1'b0;
        repeat (2) @(negedge hwclk);
        resetN = 1'b1;
    endtask

    task automatic relock();
        @(negedge hwclk);
        lock_req = 1'b1;
        @(negedge hwclk);
        lock_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({unlocked, ok_pulse, err_pulse, locked_out, state_o, digits_entered} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {unlocked, ok_pulse, err_pulse, locked_out, state_o, digits_entered});
        end
    endtask

    task automatic test_unlock_relock();
        do_reset();
        key_press(4'h6); key_press(4'h6); key_press(4'h6);
        checks++;
        if (digits_entered !== 3'd3) begin errors++; $display("FAIL digits_3: got %0d want 3", digits_entered); end
        key_press(4'h6); key_press(4'h6); key_press(4'h6);
        key_press(4'hA);
        checks++;
        if (state_o !== 3'd1 || unlocked !== 1'b1 || ok_pulse !== 1'b1 || digits_entered !== 3'd0) begin
            errors++;
            $display("FAIL unlock: state %0d unl %b ok %b dig %0d want 1 1 1 0", state_o, unlocked, ok_pulse, digits_entered);
        end
        @(negedge hwclk);
        checks++;
        if (ok_pulse !== 1'b0) begin errors++; $display("FAIL ok_width: got %b want 0", ok_pulse); end
        relock();
        checks++;
        if (state_o !== 3'd0 || unlocked !== 1'b0 || ok_pulse !== 1'b1) begin
            errors++;
            $display("FAIL relock: state %0d unl %b ok %b want 0 0 1", state_o, unlocked, ok_pulse);
        end
    endtask

    task automatic test_clear_saturate();
        do_reset();
        key_press(4'h6); key_press(4'h6); key_press(4'h6);
        key_press(4'hB);
        checks++;
        if (digits_entered !== 3'd0 || state_o !== 3'd0 || ok_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clr_key: dig %0d state %0d ok %b err %b want 0 0 0 0", digits_entered, state_o, ok_pulse, err_pulse);
        end
        for (int i = 0; i < 8; i++) key_press(4'h6);
        checks++;
        if (digits_entered !== 3'd6) begin errors++; $display("FAIL saturate: got %0d want 6", digits_entered); end
        key_press(4'hE);
        checks++;
        if (digits_entered !== 3'd6 || state_o !== 3'd0) begin
            errors++;
            $display("FAIL ignore_key: dig %0d state %0d want 6 0", digits_entered, state_o);
        end
        key_press(4'hA);
        checks++;
        if (state_o !== 3'd1 || ok_pulse !== 1'b1) begin
            errors++;
            $display("FAIL sat_unlock: state %0d ok %b want 1 1", state_o, ok_pulse);
        end
        // Mismatch in OPEN stays OPEN with an error pulse.
        key_press(4'h1); key_press(4'hA);
        checks++;
        if (state_o !== 3'd1 || err_pulse !== 1'b1 || ok_pulse !== 1'b0) begin
            errors++;
            $display("FAIL open_mismatch: state %0d err %b ok %b want 1 1 0", state_o, err_pulse, ok_pulse);
        end
        relock();
        key_press(4'h6); key_press(4'h6); key_press(4'h6); key_press(4'hA);
        checks++;
        if (state_o !== 3'd0 || err_pulse !== 1'b1 || ok_pulse !== 1'b0) begin
            errors++;
            $display("FAIL short_entry: state %0d err %b ok %b want 0 1 0", state_o, err_pulse, ok_pulse);
        end
    endtask

    task automatic test_lockout();
        int cnt;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            enter_code(24'h123456);
            checks++;
            if (err_pulse !== 1'b1) begin errors++; $display("FAIL wrong_%0d_err: got %b want 1", t, err_pulse); end
            checks++;
            if (locked_out !== (t == 2)) begin
                errors++;
                $display("FAIL wrong_%0d_lockout: got %b want %b", t, locked_out, (t == 2));
            end
        end
        checks++;
        if (state_o !== 3'd4) begin errors++; $display("FAIL lockout_state: got %0d want 4", state_o); end
        cnt = 1;
        enter_code(24'h666666);
        cnt += 14;
        checks++;
        if (state_o !== 3'd4 || ok_pulse !== 1'b0 || digits_entered !== 3'd0) begin
            errors++;
            $display("FAIL lockout_ignore: state %0d ok %b dig %0d want 4 0 0", state_o, ok_pulse, digits_entered);
        end
        for (int i = 0; i < 200 && locked_out; i++) begin
            @(negedge hwclk);
            if (locked_out) cnt++;
        end
        checks++;
        if (cnt !== 50 || locked_out !== 1'b0) begin
            errors++;
            $display("FAIL lockout_len: got %0d cycles (still %b) want 50", cnt, locked_out);
        end
        checks++;
        if (state_o !== 3'd0 || ok_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL lockout_exit: state %0d ok %b err %b want 0 0 0", state_o, ok_pulse, err_pulse);
        end
        // fail count restarted: two wrong codes must not lock out again
        enter_code(24'h123456);
        enter_code(24'h123456);
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("FAIL fail_cnt_cleared: state %0d want 0", state_o); end
        enter_code(24'h666666);
        checks++;
        if (state_o !== 3'd1 || ok_pulse !== 1'b1) begin
            errors++;
            $display("FAIL post_lockout_unlock: state %0d ok %b want 1 1", state_o, ok_pulse);
        end
    endtask

    task automatic test_reprogram();
        do_reset();
        enter_code(24'h555116);
        checks++;
        if (state_o !== 3'd2 || ok_pulse !== 1'b1) begin
            errors++;
            $display("FAIL master: state %0d ok %b want 2 1", state_o, ok_pulse);
        end
        enter_code(24'h123456);
        checks++;
        if (state_o !== 3'd3 || ok_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL new_code: state %0d ok %b err %b want 3 0 0", state_o, ok_pulse, err_pulse);
        end
        enter_code(24'h123456);
        checks++;
        if (state_o !== 3'd0 || ok_pulse !== 1'b1) begin
            errors++;
            $display("FAIL confirm: state %0d ok %b want 0 1", state_o, ok_pulse);
        end
        enter_code(24'h666666);
        checks++;
        if (state_o !== 3'd0 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL old_code_rejected: state %0d err %b want 0 1", state_o, err_pulse);
        end
        enter_code(24'h123456);
        checks++;
        if (state_o !== 3'd1 || ok_pulse !== 1'b1) begin
            errors++;
            $display("FAIL new_code_unlock: state %0d ok %b want 1 1", state_o, ok_pulse);
        end
    endtask

    task automatic test_confirm_fail();
        do_reset();
        enter_code(24'h555116);
        enter_code(24'h123456);
        enter_code(24'h999999);
        checks++;
        if (state_o !== 3'd0 || err_pulse !== 1'b1 || ok_pulse !== 1'b0) begin
            errors++;
            $display("FAIL confirm_mismatch: state %0d err %b ok %b want 0 1 0", state_o, err_pulse, ok_pulse);
        end
        enter_code(24'h666666);
        checks++;
        if (state_o !== 3'd1) begin errors++; $display("FAIL uc_unchanged: state %0d want 1", state_o); end
        // short entry in NEW_CODE aborts with an error
        do_reset();
        enter_code(24'h555116);
        key_press(4'h1); key_press(4'hA);
        checks++;
        if (state_o !== 3'd0 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL new_code_short: state %0d err %b want 0 1", state_o, err_pulse);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enter_code(24'h555116);
        enter_code(24'h123456);
        do_reset();
        checks++;
        if ({unlocked, ok_pulse, err_pulse, locked_out, state_o, digits_entered} !== 10'b0) begin
            errors++;
            $display("FAIL reset_in_confirm: got %b want 0", {unlocked, ok_pulse, err_pulse, locked_out, state_o, digits_entered});
        end
        enter_code(24'h123456);
        checks++;
        if (state_o !== 3'd0 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL pending_dropped: state %0d err %b want 0 1", state_o, err_pulse);
        end
        enter_code(24'h123456);
        enter_code(24'h123456);
        checks++;
        if (locked_out !== 1'b1) begin errors++; $display("FAIL reach_lockout: got %b want 1", locked_out); end
        do_reset();
        checks++;
        if (locked_out !== 1'b0 || state_o !== 3'd0 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_lockout: lo %b state %0d err %b want 0 0 0", locked_out, state_o, err_pulse);
        end
        enter_code(24'h666666);
        checks++;
        if (state_o !== 3'd1) begin errors++; $display("FAIL reset_uc: state %0d want 1", state_o); end
    endtask

    task automatic test_lock_req_priority();
        do_reset();
        @(negedge hwclk);
        lock_req = 1'b1;
        @(negedge hwclk);
        lock_req = 1'b0;
        checks++;
        if (state_o !== 3'd0 || ok_pulse !== 1'b0) begin
            errors++;
            $display("FAIL lock_req_in_locked: state %0d ok %b want 0 0", state_o, ok_pulse);
        end
        enter_code(24'h666666);
        @(negedge hwclk);
        lock_req  = 1'b1;
        key_valid = 1'b1;
        key       = 4'h6;
        @(negedge hwclk);
        lock_req  = 1'b0;
        key_valid = 1'b0;
        checks++;
        if (state_o !== 3'd0 || ok_pulse !== 1'b1 || digits_entered !== 3'd0) begin
            errors++;
            $display("FAIL lock_req_wins: state %0d ok %b dig %0d want 0 1 0", state_o, ok_pulse, digits_entered);
        end
        enter_code(24'h666666);
        enter_code(24'h666666);
        checks++;
        if (state_o !== 3'd0 || ok_pulse !== 1'b1) begin
            errors++;
            $display("FAIL enter_relock: state %0d ok %b want 0 1", state_o, ok_pulse);
        end
    endtask

`ifdef KEYLOCK_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        enter_code(24'h555116);
        repeat (19) @(negedge hwclk);
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL timeout_early: state %0d want 2", state_o); end
        @(negedge hwclk);
        checks++;
        if (state_o !== 3'd0 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: state %0d err %b want 0 1", state_o, err_pulse);
        end
    endtask
`endif

    initial begin
        resetN    = 1'b0;
        key_valid = 1'b0;
        key       = 4'h0;
        lock_req  = 1'b0;
        test_reset();
        test_unlock_relock();
        test_clear_saturate();
        test_lockout();
        test_reprogram();
        test_confirm_fail();
        test_reset_mid();
        test_lock_req_priority();
`ifdef KEYLOCK_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
